// File: rtl/i2c_slave.sv
// I2C responder (target) with a fixed 7-bit address.
// Receives written bytes on data_recv, returns data_send on reads.
// Ports:
//   clk             system clock, all registers on rising edge
//   arst            asynchronous active-high reset
//   scl             bus clock from the initiator (asynchronous to clk)
//   sda             open-drain bus data; only 1'b0 or 1'bz is driven
//   data_send       byte returned on a read, sampled while data_req is high
//   data_req        one-clk pulse in the cycle data_send is loaded
//   data_recv       last byte written by the initiator
//   data_recv_valid one-clk pulse when data_recv updates
//   rw              R/W bit of the current transaction (1 = read)
//   busy            high from an address match until STOP, START or a NACKed read
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] data_send,
  output logic       data_req,
  output logic [7:0] data_recv,
  output logic       data_recv_valid,
  output logic       rw,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_scl_s1, r_scl_s2, r_scl_d;
  logic       r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic       r_oe, w_oe_nxt;
  logic       r_ack_n, w_ack_n_nxt;
  logic       w_rw_nxt, w_recv_upd;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_match, w_bit_done;

  // Reset gates the pull-down directly so the bus is freed without waiting for clk.
  assign sda = (r_oe && !arst) ? 1'b0 : 1'bz;

  // Synchronizers with one history flop each; idle bus level is high.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_match    = (r_shift[7:1] == SLAVE_ADDR);
  assign w_bit_done = (r_cnt == 4'd8);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:     if (w_scl_fall && w_bit_done) w_state_nxt = w_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK: if (w_scl_fall) w_state_nxt = rw ? S_RD : S_WR;
        S_WR:       if (w_scl_fall && w_bit_done) w_state_nxt = S_WR_ACK;
        S_WR_ACK:   if (w_scl_fall) w_state_nxt = S_WR;
        S_RD:       if (w_scl_fall && w_bit_done) w_state_nxt = S_RD_ACK;
        S_RD_ACK:   if (w_scl_fall) w_state_nxt = r_ack_n ? S_WAIT_STOP : S_RD;
        default:    w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_oe_nxt    = r_oe;
    w_ack_n_nxt = r_ack_n;
    w_rw_nxt    = rw;
    w_recv_upd  = 1'b0;
    data_req    = 1'b0;
    busy        = (r_state inside {S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK});
    if (w_start || w_stop) begin
      // A repeated START stays in ADDR, so the counter is cleared explicitly here.
      w_oe_nxt  = 1'b0;
      w_cnt_nxt = 4'd0;
    end else begin
      if (w_scl_rise && (r_state inside {S_ADDR, S_WR, S_RD})) w_cnt_nxt = r_cnt + 4'd1;
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) w_shift_nxt = {r_shift[6:0], r_sda_s2};
          if (w_scl_fall && w_bit_done) begin
            w_oe_nxt = w_match;
            if (w_match) w_rw_nxt = r_shift[0];
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (rw) begin
              data_req    = 1'b1;
              w_shift_nxt = data_send;
              w_oe_nxt    = ~data_send[7];
            end else begin
              w_oe_nxt = 1'b0;
            end
          end
        end
        S_WR: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], r_sda_s2};
            w_recv_upd  = (r_cnt == 4'd7);
          end
          if (w_scl_fall && w_bit_done) w_oe_nxt = 1'b1;
        end
        S_WR_ACK: if (w_scl_fall) w_oe_nxt = 1'b0;
        S_RD: begin
          // Present the next bit after each falling edge; release for the ACK slot.
          if (w_scl_fall) begin
            if (w_bit_done) begin
              w_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_oe_nxt    = ~r_shift[6];
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) w_ack_n_nxt = r_sda_s2;
          if (w_scl_fall) begin
            if (!r_ack_n) begin
              data_req    = 1'b1;
              w_shift_nxt = data_send;
              w_oe_nxt    = ~data_send[7];
            end else begin
              w_oe_nxt = 1'b0;
            end
          end
        end
        default: ;
      endcase
      if (w_state_nxt != r_state) w_cnt_nxt = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt           <= 4'd0;
      r_shift         <= 8'h00;
      r_oe            <= 1'b0;
      r_ack_n         <= 1'b1;
      rw              <= 1'b0;
      data_recv       <= 8'h00;
      data_recv_valid <= 1'b0;
    end else begin
      r_cnt           <= w_cnt_nxt;
      r_shift         <= w_shift_nxt;
      r_oe            <= w_oe_nxt;
      r_ack_n         <= w_ack_n_nxt;
      rw              <= w_rw_nxt;
      data_recv_valid <= w_recv_upd;
      if (w_recv_upd) data_recv <= w_shift_nxt;
    end
  end

endmodule
